// File: rtl/ahb_pkg.sv
// Shared types and constants for the two-master AHB-lite arbiter.
// State encoding doubles as the one-hot grant vector {M1, M0}.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUS_M0 = 2'b01,
        BUS_M1 = 2'b10
    } arb_state_t;

    localparam logic HTRANS_IDLE   = 1'b0;
    localparam logic HTRANS_ACTIVE = 1'b1;
    localparam logic HBURST_SINGLE = 1'b0;
    localparam logic HBURST_INCR   = 1'b1;

    localparam int ADDR_W_DEF = 31;
    localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/ahb_rr_arbiter.sv
// Round-robin pick between two requesters; purely combinational, result only
// meaningful when en is high (outside the window the caller holds its grant).
module ahb_rr_arbiter (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       en,
    output logic [1:0] grant_next
);

    always_comb begin
        grant_next = 2'b00;
        if (en) begin
            case (req)
                2'b01:   grant_next = 2'b01;
                2'b10:   grant_next = 2'b10;
                // On a tie the master that did not win last time goes next.
                2'b11:   grant_next = last ? 2'b01 : 2'b10;
                default: grant_next = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// Two-master AHB-lite arbiter + address/data mux; grant registered one edge after request.
// HREADY=0 freezes owner, beat counter and data-phase select; bursts hold the bus to completion.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_LEN = 4
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              M0_HBUSREQ,
    input  logic              M0_HTRANS,
    input  logic              M0_HWRITE,
    input  logic              M0_HBURST,
    input  logic [ADDR_W-1:0] M0_HADDR,
    input  logic [DATA_W-1:0] M0_HWDATA,
    input  logic              M1_HBUSREQ,
    input  logic              M1_HTRANS,
    input  logic              M1_HWRITE,
    input  logic              M1_HBURST,
    input  logic [ADDR_W-1:0] M1_HADDR,
    input  logic [DATA_W-1:0] M1_HWDATA,
    input  logic              HREADY,
    output logic              M0_HGRANT,
    output logic              M1_HGRANT,
    output logic              HMASTER,
    output logic              HTRANS,
    output logic              HWRITE,
    output logic              HBURST,
    output logic [ADDR_W-1:0] HADDR,
    output logic [DATA_W-1:0] HWDATA,
    output logic              HSEL1,
    output logic              HREADY_Prev
);

    localparam int CNT_W = $clog2(BURST_LEN);

    arb_state_t       state, state_next;
    logic             last, last_next;
    logic             hmaster_q, hmaster_next;
    logic             hmaster_d;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             acc, window;
    logic [1:0]       grant_rr;
    logic             trans_src, write_src, burst_src;

    // Address phase follows HMASTER; data phase follows the owner of the previous accepted phase.
    assign HADDR     = hmaster_q ? M1_HADDR  : M0_HADDR;
    assign trans_src = hmaster_q ? M1_HTRANS : M0_HTRANS;
    assign write_src = hmaster_q ? M1_HWRITE : M0_HWRITE;
    assign burst_src = hmaster_q ? M1_HBURST : M0_HBURST;
    assign HWDATA    = hmaster_d ? M1_HWDATA : M0_HWDATA;

    assign HTRANS      = (state == IDLE) ? HTRANS_IDLE   : trans_src;
    assign HWRITE      = (state == IDLE) ? 1'b0          : write_src;
    assign HBURST      = (state == IDLE) ? HBURST_SINGLE : burst_src;
    assign HSEL1       = HTRANS;
    assign HREADY_Prev = HREADY;
    assign HMASTER     = hmaster_q;
    assign M0_HGRANT   = (state == BUS_M0);
    assign M1_HGRANT   = (state == BUS_M1);

    always_comb begin
        acc      = HREADY && (HTRANS == HTRANS_ACTIVE);
        cnt_next = cnt;
        if (acc && (cnt == '0) && (HBURST == HBURST_INCR))
            cnt_next = CNT_W'(BURST_LEN - 1);
        else if (acc && (cnt != '0))
            cnt_next = cnt - CNT_W'(1);
        // Looking at cnt_next locks the bus on the very first beat of a burst.
        window = HREADY && (cnt_next == '0);
    end

    ahb_rr_arbiter u_rr (
        .req        ({M1_HBUSREQ, M0_HBUSREQ}),
        .last       (last),
        .en         (window),
        .grant_next (grant_rr)
    );

    always_comb begin
        state_next   = state;
        last_next    = last;
        hmaster_next = hmaster_q;
        if (window) begin
            case (grant_rr)
                2'b01: begin
                    state_next   = BUS_M0;
                    hmaster_next = 1'b0;
                end
                2'b10: begin
                    state_next   = BUS_M1;
                    hmaster_next = 1'b1;
                end
                default: state_next = IDLE;
            endcase
            if ((state_next != state) && (state_next != IDLE))
                last_next = hmaster_next;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state     <= IDLE;
            last      <= 1'b1;
            hmaster_q <= 1'b0;
            hmaster_d <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_next;
            last      <= last_next;
            hmaster_q <= hmaster_next;
            cnt       <= cnt_next;
            if (HREADY)
                hmaster_d <= hmaster_q;
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed test-plan scenarios plus a saturated random phase whose expected beat
// stream is the strict per-transfer alternation M0,M1,M0,... of two random scripts.
module tb_ahb_arbiter;

    localparam int ADDR_W    = 31;
    localparam int DATA_W    = 32;
    localparam int BURST_LEN = 4;
    localparam int NT        = 10;
    localparam int LIMIT     = 4000;

    logic              HCLK = 1'b0;
    logic              HRESET;
    logic              M0_HBUSREQ, M0_HTRANS, M0_HWRITE, M0_HBURST;
    logic [ADDR_W-1:0] M0_HADDR;
    logic [DATA_W-1:0] M0_HWDATA;
    logic              M1_HBUSREQ, M1_HTRANS, M1_HWRITE, M1_HBURST;
    logic [ADDR_W-1:0] M1_HADDR;
    logic [DATA_W-1:0] M1_HWDATA;
    logic              HREADY;
    logic              M0_HGRANT, M1_HGRANT, HMASTER;
    logic              HTRANS, HWRITE, HBURST, HSEL1, HREADY_Prev;
    logic [ADDR_W-1:0] HADDR;
    logic [DATA_W-1:0] HWDATA;

    ahb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .M0_HBUSREQ(M0_HBUSREQ), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE),
        .M0_HBURST(M0_HBURST), .M0_HADDR(M0_HADDR), .M0_HWDATA(M0_HWDATA),
        .M1_HBUSREQ(M1_HBUSREQ), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE),
        .M1_HBURST(M1_HBURST), .M1_HADDR(M1_HADDR), .M1_HWDATA(M1_HWDATA),
        .HREADY(HREADY),
        .M0_HGRANT(M0_HGRANT), .M1_HGRANT(M1_HGRANT), .HMASTER(HMASTER),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HBURST(HBURST),
        .HADDR(HADDR), .HWDATA(HWDATA), .HSEL1(HSEL1), .HREADY_Prev(HREADY_Prev)
    );

    initial forever #5 HCLK = ~HCLK;

    typedef struct {
        logic              m;
        logic [ADDR_W-1:0] addr;
        logic              w;
        logic              b;
        logic [DATA_W-1:0] data;
    } beat_t;

    beat_t exp_q[$];
    beat_t plan0[$];
    beat_t plan1[$];
    beat_t dph;
    logic  dph_vld = 1'b0;
    logic  mon_en  = 1'b0;
    int    checks  = 0;
    int    errors  = 0;
    int    p0 = 0, p1 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_inputs();
        M0_HBUSREQ = 0; M0_HTRANS = 0; M0_HWRITE = 0; M0_HBURST = 0; M0_HADDR = '0; M0_HWDATA = '0;
        M1_HBUSREQ = 0; M1_HTRANS = 0; M1_HWRITE = 0; M1_HBURST = 0; M1_HADDR = '0; M1_HWDATA = '0;
    endtask

    task automatic pulse_reset();
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        tick();
    endtask

    // Transfers in the expected queue interleave M0 t, M1 t, M0 t+1, ... since both always request.
    task automatic build_plan();
        beat_t             x;
        logic              burst, wr;
        int                n;
        logic [ADDR_W-1:0] base;
        for (int t = 0; t < NT; t++) begin
            for (int m = 0; m < 2; m++) begin
                burst = 1'($urandom_range(1));
                wr    = 1'($urandom_range(1));
                n     = burst ? BURST_LEN : 1;
                base  = ADDR_W'((m == 1) ? 32'h2000 : 32'h1000) + ADDR_W'(t * 16);
                for (int b = 0; b < n; b++) begin
                    x.m    = 1'(m);
                    x.addr = base + ADDR_W'(b);
                    x.w    = wr;
                    x.b    = burst;
                    x.data = $urandom;
                    if (m == 0) plan0.push_back(x);
                    else        plan1.push_back(x);
                    exp_q.push_back(x);
                end
            end
        end
    endtask

    task automatic drive_masters();
        M0_HBUSREQ = (p0 < plan0.size());
        if (M0_HGRANT && p0 < plan0.size()) begin
            M0_HTRANS = 1; M0_HADDR = plan0[p0].addr; M0_HWRITE = plan0[p0].w; M0_HBURST = plan0[p0].b;
        end else begin
            M0_HTRANS = 0; M0_HBURST = 0;
        end
        M1_HBUSREQ = (p1 < plan1.size());
        if (M1_HGRANT && p1 < plan1.size()) begin
            M1_HTRANS = 1; M1_HADDR = plan1[p1].addr; M1_HWRITE = plan1[p1].w; M1_HBURST = plan1[p1].b;
        end else begin
            M1_HTRANS = 0; M1_HBURST = 0;
        end
    endtask

    // Monitor: every accepted address phase pops one expected beat; its data phase is checked later.
    initial begin
        beat_t e;
        forever begin
            @(negedge HCLK);
            if (mon_en) begin
                if (dph_vld && HREADY) begin
                    check("hwdata", HWDATA, dph.data);
                    dph_vld = 1'b0;
                end
                if (HTRANS && HREADY) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: HADDR 0x%0h with empty queue", HADDR);
                    end else begin
                        e = exp_q.pop_front();
                        check("hmaster", HMASTER, e.m);
                        check("haddr",   HADDR,   e.addr);
                        check("hwrite",  HWRITE,  e.w);
                        check("hburst",  HBURST,  e.b);
                        dph     = e;
                        dph_vld = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        logic acc0, acc1;
        int   cyc;

        idle_inputs();
        HREADY = 1'b1;
        HRESET = 1'b1;
        tick();
        tick();
        check("rst_grants", {M1_HGRANT, M0_HGRANT}, 2'b00);
        check("rst_hsel1", HSEL1, 0);
        check("rst_hmaster", HMASTER, 0);
        check("rst_htrans", HTRANS, 0);
        HRESET = 1'b0;
        tick();

        // Single write from M0
        M0_HBUSREQ = 1;
        tick();
        check("single_grant", {M1_HGRANT, M0_HGRANT}, 2'b01);
        M0_HTRANS = 1; M0_HWRITE = 1; M0_HADDR = 'h10; M0_HBUSREQ = 0;
        #1;
        check("single_haddr", HADDR, 'h10);
        check("single_hsel1", HSEL1, 1);
        check("single_hwrite", HWRITE, 1);
        tick();
        M0_HTRANS = 0; M0_HWRITE = 0; M0_HWDATA = 32'hA5A5_0001;
        #1;
        check("single_hwdata", HWDATA, 32'hA5A5_0001);
        check("single_release", {M1_HGRANT, M0_HGRANT}, 2'b00);

        // Tie from IDLE, then per-transfer alternation
        pulse_reset();
        M0_HBUSREQ = 1; M1_HBUSREQ = 1;
        tick();
        for (int k = 0; k < 4; k++) begin
            check("tie_alternate", {M1_HGRANT, M0_HGRANT}, (k % 2 == 0) ? 2'b01 : 2'b10);
            M0_HTRANS = (k % 2 == 0);
            M1_HTRANS = (k % 2 == 1);
            M0_HADDR = ADDR_W'('h30 + k);
            M1_HADDR = ADDR_W'('h30 + k);
            tick();
        end
        M0_HBUSREQ = 0; M1_HBUSREQ = 0; M0_HTRANS = 0; M1_HTRANS = 0;
        tick();
        check("tie_idle", {M1_HGRANT, M0_HGRANT}, 2'b00);

        // M1 burst with M0 contending, wait states during beat 2
        M1_HBUSREQ = 1;
        tick();
        check("burst_grant", {M1_HGRANT, M0_HGRANT}, 2'b10);
        M0_HBUSREQ = 1; M1_HTRANS = 1; M1_HBURST = 1; M1_HWRITE = 1;
        for (int b = 0; b < 4; b++) begin
            M1_HADDR = ADDR_W'('h20 + b);
            #1;
            check("burst_haddr", HADDR, 'h20 + b);
            if (b == 1) begin
                HREADY = 1'b0;
                repeat (3) begin
                    tick();
                    check("wait_grants", {M1_HGRANT, M0_HGRANT}, 2'b10);
                    check("wait_hmaster", HMASTER, 1);
                    check("wait_hready_prev", HREADY_Prev, 0);
                end
                HREADY = 1'b1;
            end
            tick();
            check((b < 3) ? "burst_hold" : "burst_handover", {M1_HGRANT, M0_HGRANT}, (b < 3) ? 2'b10 : 2'b01);
        end
        check("handover_hmaster", HMASTER, 0);
        M1_HTRANS = 0; M1_HBURST = 0; M1_HBUSREQ = 0;

        // Reset asserted asynchronously during beat 3 of an M0 burst
        M0_HTRANS = 1; M0_HBURST = 1; M0_HWRITE = 1;
        for (int b = 0; b < 2; b++) begin
            M0_HADDR = ADDR_W'('h40 + b);
            tick();
        end
        M0_HADDR = 'h42;
        #1;
        HRESET = 1'b1;
        #1;
        check("arst_grants", {M1_HGRANT, M0_HGRANT}, 2'b00);
        check("arst_hsel1", HSEL1, 0);
        check("arst_hmaster", HMASTER, 0);
        check("arst_hburst", HBURST, 0);
        idle_inputs();
        tick();
        HRESET = 1'b0;
        tick();
        M1_HBUSREQ = 1;
        #1;
        check("post_rst_not_yet", M1_HGRANT, 0);
        tick();
        check("post_rst_grant", {M1_HGRANT, M0_HGRANT}, 2'b10);
        check("post_rst_hmaster", HMASTER, 1);

        // Random saturated phase with random wait states
        M1_HBUSREQ = 0;
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        build_plan();
        mon_en = 1'b1;
        cyc = 0;
        while ((exp_q.size() != 0 || dph_vld) && cyc < LIMIT) begin
            drive_masters();
            HREADY = ($urandom_range(3) != 0);
            @(negedge HCLK);
            acc0 = HREADY && M0_HTRANS && M0_HGRANT;
            acc1 = HREADY && M1_HTRANS && M1_HGRANT;
            @(posedge HCLK);
            #1;
            if (acc0) begin M0_HWDATA = plan0[p0].data; p0++; end
            if (acc1) begin M1_HWDATA = plan1[p1].data; p1++; end
            cyc++;
        end
        mon_en = 1'b0;
        checks++;
        if (cyc >= LIMIT) begin
            errors++;
            $display("FAIL rand_timeout: %0d beats still expected after %0d cycles", exp_q.size(), cyc);
        end
        check("m0_beats_done", p0, plan0.size());
        check("m1_beats_done", p1, plan1.size());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Two-master AHB-lite arbiter and bus multiplexer placed in front of the shared `Memory` slave. It accepts bus requests from master 0 and master 1 and grants the bus round-robin. Incrementing bursts are held to completion. It muxes the granted master's address/control in the address phase and its write data one phase later, and drives `HSEL1`/`HREADY_Prev` into the memory.

## Interface
- `ADDR_W`, 31, address width (matches memory `HADDR`)
- `DATA_W`, 32, data width
- `BURST_LEN`, 4, beats in an `HBURST=1` burst (≥2)
- `HCLK  in  1  ` single clock, rising edge
- `HRESET  in  1  ` reset, asynchronous, active-high
- `M0_HBUSREQ`, `M1_HBUSREQ  in  1  ` bus request
- `M0_HTRANS`, `M1_HTRANS  in  1  ` 1=active transfer, 0=idle
- `M0_HWRITE`, `M1_HWRITE  in  1  ` 1=write
- `M0_HBURST`, `M1_HBURST  in  1  ` 0=single, 1=incrementing burst of `BURST_LEN`
- `M0_HADDR`, `M1_HADDR  in  ADDR_W  ` address
- `M0_HWDATA`, `M1_HWDATA  in  DATA_W  ` write data
- `HREADY  in  1  ` ready from memory
- `M0_HGRANT`, `M1_HGRANT  out  1  ` registered grant
- `HMASTER  out  1  ` address-phase owner
- `HTRANS`, `HWRITE`, `HBURST  out  1  ` muxed control to memory
- `HADDR  out  ADDR_W  `, `HWDATA  out  DATA_W  ` muxed to memory
- `HSEL1  out  1  ` memory select
- `HREADY_Prev  out  1  ` equals `HREADY` (bus ready fed back)

## Operation
- **FSM states:** `IDLE`, `BUS_M0`, `BUS_M1`. Grants are one-hot: `IDLE`→00, `BUS_M0`→01, `BUS_M1`→10.
- **Address mux:** select is `HMASTER`. In `IDLE`, `HTRANS`, `HWRITE` and `HBURST` are forced to 0. `HADDR` still shows the `HMASTER` source.
- **Data mux:** select is `hmaster_d`, i.e. `HMASTER` registered on edges with `HREADY=1`.
- `HSEL1 = HTRANS`.
- **Beat counter `cnt`:**
  - Let `acc = HREADY & HTRANS`.
  - If `acc` and `cnt==0` and `HBURST`, load `BURST_LEN-1`.
  - Else if `acc` and `cnt!=0`, decrement.
  - Otherwise hold.
- **Arbitration window:** an edge with `HREADY=1` and `cnt_next==0`. Outside the window the FSM, grants and `HMASTER` hold.
- **Decision in window (round-robin, pointer `last`):**
  - No request → `IDLE`.
  - One requester → that master.
  - Both requesting → the master ≠ `last`, even if it is the current owner's peer (per-transfer fairness).
- `last` updates to the newly granted master on every grant change.
- `HMASTER` loads the new owner at the same edge as the grant. In `IDLE`, `HMASTER` holds.
- A burst started in the current address phase locks arbitration immediately, because `cnt_next≠0`.

## Timing
- **Reset values:**
  - State `IDLE`, both `HGRANT` 0, `HMASTER` 0, `hmaster_d` 0, `cnt` 0, `last` 1 (M0 wins the first tie).
  - `HTRANS`, `HWRITE`, `HBURST` 0, so `HSEL1` 0.
- Reset asserted mid-burst returns everything to the reset values asynchronously. The in-flight data phase is abandoned.
- **Grant latency:** request sampled at edge N from `IDLE` → `HGRANT` high after edge N. The master drives its address phase in cycle N+1, and it appears combinationally on `HADDR`/`HTRANS`. Write data is muxed in cycle N+2.
- **Handover:** at edge E, the old owner's address phase (cycle before E) completes. The new owner's address phase is the cycle after E, while the old owner's data phase is still muxed via `hmaster_d`.
- **Wait states:** `HREADY=0` freezes FSM, `cnt`, `HMASTER` and `hmaster_d`.
- An owner dropping `HBUSREQ` mid-burst is ignored until `cnt` reaches 0.
- A master that is granted but drives `HTRANS=0` keeps the bus only while no other master requests.

## Structure
- Package `ahb_pkg` holds:
  - the state enum `arb_state_t {IDLE, BUS_M0, BUS_M1}`;
  - `HTRANS_IDLE`/`HTRANS_ACTIVE` and `HBURST_SINGLE`/`HBURST_INCR` constants;
  - default `ADDR_W`/`DATA_W`.
- One sub-module, `ahb_rr_arbiter`:
  - inputs: 2-bit request, `last` pointer, window enable;
  - output: next grant.
- Muxes, counter and registers stay in `ahb_arbiter`.

## Test plan
- **Reset:** `HRESET=1` → grants 00, `HSEL1=0`, `HMASTER=0`.
- **Single requester:** release; M0 requests a single write to `0x10` with data `0xA5A5_0001` → `M0_HGRANT` is 1 one cycle later, memory sees `HADDR=0x10`, then `HWDATA=0xA5A5_0001`.
- **Tie then alternation:** M0 and M1 request simultaneously from `IDLE` → M0 granted first. With both still requesting, the grant alternates M1, M0, M1 on successive single transfers.
- **Burst hold:** M1 issues a 4-beat burst to `0x20`–`0x23` while M0 requests → M1 keeps the grant for all 4 accepted beats. M0 is granted at the edge accepting beat 4.
- **Wait state mid-burst:** hold `HREADY=0` 3 cycles during beat 2 → `cnt`, grants and `HMASTER` frozen. The burst completes with 4 beats total.
- **Reset mid-burst:** assert `HRESET` during beat 3 → outputs return to reset values without waiting for an edge. After release, the next request from `IDLE` gets its grant one cycle later.
